// File: rtl/if_fetch.sv
// Instruction-fetch stage feeding the IF/ID pipeline register.
// Owns the PC and keeps at most one request outstanding on a req/gnt/rvalid
// instruction-memory port. The fetched instruction is presented to IF/ID and
// held there while IF/ID stalls. A branch or flush redirects the PC, and any
// response still in flight for the old PC is discarded.
// Ports:
//   clk, rst           clock; asynchronous active-low reset
//   stall              IF/ID not accepting; hold the presented instruction
//   redirect_en/_pc    branch/flush request and its target (bits [1:0] dropped)
//   imem_req/_addr     fetch request and word address (always the PC)
//   imem_gnt           request accepted this cycle
//   imem_rvalid/_rdata response for the outstanding request
//   if_pc/_inst/_valid instruction presented to IF/ID (zeros when not valid)
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t            r_state;
  logic [XLEN-1:0]   r_pc;
  logic              r_kill;
  logic              r_req;
  logic [XLEN-1:0]   r_if_pc;
  logic [XLEN-1:0]   r_if_inst;
  logic              r_if_valid;

  state_t            w_state_nx;
  logic [XLEN-1:0]   w_pc_nx;
  logic              w_kill_nx;
  logic [XLEN-1:0]   w_if_pc_nx;
  logic [XLEN-1:0]   w_if_inst_nx;
  logic              w_if_valid_nx;
  logic [XLEN-1:0]   w_redir_pc;

  // Redirect targets are word aligned.
  assign w_redir_pc = redirect_pc & ~XLEN'(32'h3);

  assign imem_req  = r_req;
  assign imem_addr = r_pc;
  assign if_pc     = r_if_pc;
  assign if_inst   = r_if_inst;
  assign if_valid  = r_if_valid;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_kill     <= 1'b0;
      r_req      <= 1'b0;
      r_if_pc    <= '0;
      r_if_inst  <= '0;
      r_if_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_pc       <= w_pc_nx;
      r_kill     <= w_kill_nx;
      r_req      <= (w_state_nx == S_REQ);
      r_if_pc    <= w_if_pc_nx;
      r_if_inst  <= w_if_inst_nx;
      r_if_valid <= w_if_valid_nx;
    end
  end

  // Next-state, PC and presentation logic.
  always_comb begin
    w_state_nx    = r_state;
    w_pc_nx       = r_pc;
    w_kill_nx     = r_kill;
    w_if_pc_nx    = r_if_pc;
    w_if_inst_nx  = r_if_inst;
    w_if_valid_nx = r_if_valid;

    case (r_state)
      S_IDLE: begin
        w_state_nx = S_REQ;
      end

      S_REQ: begin
        // Before grant the address may simply move to the new target.
        if (redirect_en) begin
          w_pc_nx = w_redir_pc;
        end
        if (imem_gnt) begin
          w_state_nx = S_WAIT;
          // The old address was already accepted; its data must be dropped.
          if (redirect_en) begin
            w_kill_nx = 1'b1;
          end
        end
      end

      S_WAIT: begin
        if (!imem_rvalid) begin
          if (redirect_en) begin
            w_pc_nx   = w_redir_pc;
            w_kill_nx = 1'b1;
          end
        end else if (r_kill || redirect_en) begin
          w_kill_nx  = 1'b0;
          w_state_nx = S_REQ;
          if (redirect_en) begin
            w_pc_nx = w_redir_pc;
          end
        end else begin
          w_if_pc_nx    = r_pc;
          w_if_inst_nx  = imem_rdata;
          w_if_valid_nx = 1'b1;
          w_state_nx    = S_OUT;
        end
      end

      S_OUT: begin
        // Redirect wins over stall; otherwise IF/ID takes it when not stalled.
        if (redirect_en) begin
          w_if_pc_nx    = '0;
          w_if_inst_nx  = '0;
          w_if_valid_nx = 1'b0;
          w_pc_nx       = w_redir_pc;
          w_state_nx    = S_REQ;
        end else if (!stall) begin
          w_if_pc_nx    = '0;
          w_if_inst_nx  = '0;
          w_if_valid_nx = 1'b0;
          w_pc_nx       = r_pc + XLEN'(PC_STEP);
          w_state_nx    = S_REQ;
        end
      end

      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_if_fetch.sv
// Testbench for if_fetch: a randomised memory responder, a reference model of
// the instruction stream IF/ID should see, and a scoreboard monitor.
module tb_if_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_en = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;

  if_fetch #(.RESET_PC(RESET_PC), .PC_STEP(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .if_pc       (if_pc),
    .if_inst     (if_inst),
    .if_valid    (if_valid)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h want %08h", name, act, exp);
  endtask

  // Memory contents: word at address 0 is 32'h1234_5678, others distinct.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // Memory responder: grants with probability rsp_prob, answers after a delay.
  int          rsp_prob = 100;
  int          rsp_dmin = 1;
  int          rsp_dmax = 1;
  bit          rsp_keep = 1'b0;
  bit          rsp_out  = 1'b0;
  int          rsp_cnt  = 0;
  logic [31:0] rsp_addr = 32'h0;

  initial forever begin
    @(posedge clk); #1;
    imem_rvalid = 1'b0;
    if (!rst && !rsp_keep) begin
      rsp_out  = 1'b0;
      imem_gnt = 1'b0;
    end else begin
      if (rsp_out) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(rsp_addr);
          rsp_out     = 1'b0;
        end
      end
      imem_gnt = 1'b0;
      if (imem_req && !rsp_out && (int'($urandom_range(99)) < rsp_prob)) begin
        imem_gnt = 1'b1;
        rsp_addr = imem_addr;
        rsp_out  = 1'b1;
        rsp_cnt  = int'($urandom_range(rsp_dmax, rsp_dmin));
      end
    end
  end

  // Reference model: the next instruction IF/ID must see is the one at the
  // latest redirect target, or the one after the last accepted instruction.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_pc   = RESET_PC;
  bit          m_up   = 1'b0;

  task automatic expect_next(input logic [31:0] p);
    exp_t e;
    e.pc   = p;
    e.inst = mem_word(p);
    sb_q.delete();
    sb_q.push_back(e);
  endtask

  initial forever begin
    @(negedge clk); #1;
    if (!rst) begin
      m_pc = RESET_PC;
      expect_next(m_pc);
    end else if (m_up) begin
      // The first cycle after reset release ignores redirects.
      if (redirect_en) begin
        m_pc = redirect_pc & 32'hFFFF_FFFC;
        expect_next(m_pc);
      end else if (if_valid && !stall) begin
        m_pc = m_pc + 32'd4;
        expect_next(m_pc);
      end
    end
    m_up = rst;
  end

  // Monitor: checks each new presentation against the scoreboard, holds under
  // stall, and zeroed outputs while nothing is presented.
  exp_t cur;
  bit   prev_v = 1'b0;

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      prev_v = 1'b0;
    end else begin
      if (if_valid && !prev_v) begin
        chk("present_expected", 32'(sb_q.size()), 32'd1);
        if (sb_q.size() != 0) begin
          cur = sb_q.pop_front();
          chk("sb_pc", if_pc, cur.pc);
          chk("sb_inst", if_inst, cur.inst);
        end
      end else if (if_valid) begin
        chk("hold_pc", if_pc, cur.pc);
        chk("hold_inst", if_inst, cur.inst);
        chk("hold_no_req", 32'(imem_req), 32'd0);
      end else begin
        chk("nop_pc", if_pc, 32'd0);
        chk("nop_inst", if_inst, 32'd0);
      end
      prev_v = if_valid;
    end
  end

  task automatic wait_req(input string name);
    int n = 0;
    while (!imem_req && n < 60) begin
      @(posedge clk); #2;
      n++;
    end
    chk({name, "_req_seen"}, 32'(imem_req), 32'd1);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!if_valid && n < 60) begin
      @(posedge clk); #2;
      n++;
    end
    chk({name, "_valid_seen"}, 32'(if_valid), 32'd1);
  endtask

  task automatic chk_reset_outs(input string name);
    chk({name, "_valid"}, 32'(if_valid), 32'd0);
    chk({name, "_pc"}, if_pc, 32'd0);
    chk({name, "_inst"}, if_inst, 32'd0);
    chk({name, "_req"}, 32'(imem_req), 32'd0);
    chk({name, "_addr"}, imem_addr, RESET_PC);
  endtask

  initial begin
    int          cnt;
    logic [31:0] tgt;

    #2;
    chk_reset_outs("rst0");
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // 1: first fetch, latency and single-cycle presentation
    cnt = 0;
    while (!imem_req && cnt < 20) begin @(posedge clk); #2; cnt++; end
    chk("t1_req_seen", 32'(imem_req), 32'd1);
    chk("t1_addr", imem_addr, 32'h0);
    cnt = 0;
    while (!if_valid && cnt < 20) begin @(posedge clk); #2; cnt++; end
    chk("t1_latency", 32'(cnt), 32'd2);
    chk("t1_pc", if_pc, 32'h0);
    chk("t1_inst", if_inst, 32'h1234_5678);
    @(posedge clk); #2;
    chk("t1_pulse", 32'(if_valid), 32'd0);
    wait_req("t1n");
    chk("t1_next_addr", imem_addr, 32'h4);

    // 2: stall holds the presentation for three extra cycles
    stall = 1'b1;
    wait_valid("t2");
    chk("t2_pc", if_pc, 32'h4);
    repeat (3) begin
      @(posedge clk); #2;
      chk("t2_hold_valid", 32'(if_valid), 32'd1);
      chk("t2_hold_req", 32'(imem_req), 32'd0);
    end
    stall    = 1'b0;
    rsp_dmin = 3;
    rsp_dmax = 3;
    @(posedge clk); #2;
    wait_req("t2n");
    chk("t2_next_addr", imem_addr, 32'h8);

    // 3: redirect while waiting; the late response is dropped
    @(posedge clk); #2;
    chk("t3_in_wait", 32'(imem_req), 32'd0);
    redirect_pc = 32'h100;
    redirect_en = 1'b1;
    @(posedge clk); #1;
    redirect_en = 1'b0;
    #1;
    wait_req("t3n");
    chk("t3_addr", imem_addr, 32'h100);
    chk("t3_no_valid", 32'(if_valid), 32'd0);

    // 4: redirect in the grant cycle; target low bits are cleared
    redirect_pc = 32'h203;
    redirect_en = 1'b1;
    @(posedge clk); #1;
    redirect_en = 1'b0;
    #1;
    wait_req("t4n");
    chk("t4_addr", imem_addr, 32'h200);
    chk("t4_no_valid", 32'(if_valid), 32'd0);
    wait_valid("t4");
    chk("t4_pc", if_pc, 32'h200);

    // 5: redirect from OUT to the top word, then PC wraps to zero
    redirect_pc = 32'hFFFF_FFFC;
    redirect_en = 1'b1;
    @(posedge clk); #1;
    redirect_en = 1'b0;
    #1;
    wait_req("t5a");
    chk("t5_addr_top", imem_addr, 32'hFFFF_FFFC);
    wait_valid("t5");
    chk("t5_pc", if_pc, 32'hFFFF_FFFC);
    @(posedge clk); #2;
    wait_req("t5b");
    chk("t5_wrap_addr", imem_addr, 32'h0);

    // Randomised traffic
    rsp_prob = 70;
    rsp_dmin = 1;
    rsp_dmax = 3;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      stall = ($urandom_range(2) == 0);
      redirect_en = ($urandom_range(11) == 0);
      tgt = $urandom;
      if ($urandom_range(3) == 0) tgt = 32'hFFFF_FFF0 + 32'($urandom_range(15));
      redirect_pc = tgt;
    end
    @(posedge clk); #1;
    stall       = 1'b0;
    redirect_en = 1'b0;
    repeat (10) @(posedge clk);

    // 6: asynchronous reset mid-wait; the stray response is ignored
    rsp_prob = 100;
    rsp_dmin = 4;
    rsp_dmax = 4;
    rsp_keep = 1'b1;
    cnt = 0;
    do begin
      @(posedge clk); #2;
      cnt++;
    end while (!(rsp_out && rsp_cnt == 1 && !imem_req) && cnt < 200);
    chk("t6_wait_seen", 32'(rsp_out && rsp_cnt == 1), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk_reset_outs("t6_async");
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("t6_stray_rvalid", 32'(imem_rvalid), 32'd1);
    @(posedge clk); #1;
    rsp_keep = 1'b0;
    rsp_dmin = 1;
    rsp_dmax = 1;
    #1;
    wait_req("t6n");
    chk("t6_restart_addr", imem_addr, RESET_PC);
    wait_valid("t6");
    chk("t6_pc", if_pc, RESET_PC);
    chk("t6_inst", if_inst, 32'h1234_5678);
    repeat (4) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
